debug_frame_tx: RTL and testbench
=================================

Name: debug_frame_tx

Overview:
Serializes a snapshot of the pipeline debug bus into a framed byte stream for the UART transmitter. It sits between the debugger receive control, which issues the send request, and the UART transmit path. It captures the wide debug bus atomically, then emits a header, a length byte, the data bytes MSB-first and an optional checksum. Each byte is handed off using the UART wr/busy handshake, and the block pulses a completion strobe at the end of the frame.

Parameters:
DATA_BYTES, 217, payload size in bytes; the bus is DATA_BYTES*8 bits; legal range 1..255.
HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
send  in  1  request to start a frame; level-sampled, acted on only in IDLE
send_data  in  DATA_BYTES*8  debug bus; captured in full in the cycle send is accepted
tx_busy  in  1  UART transmitter busy flag
wr_uart  out  1  one-cycle write strobe to the UART; registered
w_data  out  8  byte to transmit; valid while wr_uart=1; registered
data_sent  out  1  one-cycle pulse after the last byte of the frame completes
busy  out  1  high from send acceptance until data_sent
state  out  3  current FSM state, for debug LEDs

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - wr_uart=0, w_data=0, data_sent=0, busy=0, byte counter=0, checksum accumulator=0.
  - The snapshot register is cleared.
- State encoding: IDLE=0, LOAD=1, ISSUE=2, WAIT_ACK=3, WAIT_FREE=4, DONE=5.
- IDLE:
  - If send=1, latch send_data into the snapshot, set busy=1 and go to LOAD.
  - send_data changes after acceptance do not affect the frame.
- LOAD:
  - Select the header, clear the byte index and checksum, then go to ISSUE.
- ISSUE:
  - If tx_busy=0, assert wr_uart for exactly one cycle with w_data = the current byte, then go to WAIT_ACK.
  - If tx_busy=1, stay in ISSUE.
- WAIT_ACK:
  - Wait for tx_busy=1, meaning the UART accepted the byte, then go to WAIT_FREE.
  - Timeout: if tx_busy does not rise within 2 cycles, treat the byte as accepted and go to WAIT_FREE.
- WAIT_FREE:
  - Wait for tx_busy=0, then advance to the next byte.
  - If the last byte has been sent, go to DONE; otherwise go to ISSUE.
- Byte order:
  - HEADER_BYTE, then DATA_BYTES[7:0], then snapshot bytes from the most-significant byte down, then the checksum (if enabled).
  - Data byte k (k=0..DATA_BYTES-1) is snapshot[(DATA_BYTES-k)*8-1 -: 8].
- Checksum:
  - 8-bit accumulator of the data bytes only, mod 256, wrapping.
  - The byte transmitted is the two's complement (0 - sum), so data bytes + checksum = 0 mod 256.
- DONE:
  - data_sent=1 for one cycle, busy=0, return to IDLE.
  - A send held high re-triggers no earlier than the cycle after DONE.
- send while busy=1 is ignored; no queueing.
- Reset mid-frame:
  - Immediate abort to IDLE with no data_sent.
  - A wr_uart asserted in that cycle is not repeated.
- Frame length: DATA_BYTES+3 bytes with checksum, DATA_BYTES+2 bytes without.
- Minimum latency: send sampled high at edge N gives wr_uart (header) high after edge N+2.
- The byte counter is 8 bits; DATA_BYTES=255 must not wrap the counter before the last data byte.

Optional Feature:
DBG_CHECKSUM_EN:
- Defined: checksum byte appended; frame is DATA_BYTES+3 bytes.
- Undefined: no accumulator is synthesized; the last data byte leads directly to DONE; frame is DATA_BYTES+2 bytes.

Test Plan:
1. DATA_BYTES=4, send_data=32'h11223344, UART model raises busy 1 cycle after wr and holds it 10 cycles -> bytes A5,04,11,22,33,44,56 with DBG_CHECKSUM_EN (A5,04,11,22,33,44 without); then one data_sent pulse and busy=0.
2. send_data changed to 32'hFFFFFFFF one cycle after send accepted -> transmitted payload is still 11,22,33,44.
3. tx_busy held high for 50 cycles at the start of the frame -> no wr_uart while busy; header issued in the first cycle after tx_busy falls.
4. send pulsed again mid-frame -> ignored; exactly one frame and one data_sent.
5. reset asserted after the third byte -> outputs all 0 next cycle, state=0, no data_sent; a new send then produces a complete frame from the header.
6. UART model never raises busy -> WAIT_ACK timeout after 2 cycles; all 7 bytes still issued in order, one wr_uart pulse each.

Source files
------------

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: frames a debug-bus snapshot into a UART byte stream.
// Define DBG_CHECKSUM_EN to append a two's-complement checksum byte.
module debug_frame_tx #(
    parameter int         DATA_BYTES  = 217,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    send,
    input  logic [DATA_BYTES*8-1:0] send_data,
    input  logic                    tx_busy,
    output logic                    wr_uart,
    output logic [7:0]              w_data,
    output logic                    data_sent,
    output logic                    busy,
    output logic [2:0]              state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_FREE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [1:0] PH_HDR  = 2'd0;
    localparam logic [1:0] PH_LEN  = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;
`ifdef DBG_CHECKSUM_EN
    localparam logic [1:0] PH_CSUM = 2'd3;
`endif

    localparam int         W       = DATA_BYTES * 8;
    localparam logic [7:0] LEN     = 8'(DATA_BYTES);
    localparam logic [7:0] LAST    = 8'(DATA_BYTES - 1);

    // Snapshot shifts left one byte per data byte, so the MSB byte is on top.
    logic [W-1:0] snap;
    logic [1:0]   phase;
    logic [7:0]   cnt;
    logic         ack_tmo;
    logic [7:0]   cur_byte;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]   sum;
`endif

    always_comb begin
        cur_byte = HEADER_BYTE;
        case (phase)
            PH_LEN:  cur_byte = LEN;
            PH_DATA: cur_byte = snap[W-1 -: 8];
`ifdef DBG_CHECKSUM_EN
            PH_CSUM: cur_byte = 8'd0 - sum;
`endif
            default: cur_byte = HEADER_BYTE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_uart   <= 1'b0;
            w_data    <= 8'd0;
            data_sent <= 1'b0;
            busy      <= 1'b0;
            snap      <= '0;
            phase     <= PH_HDR;
            cnt       <= 8'd0;
            ack_tmo   <= 1'b0;
`ifdef DBG_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            wr_uart   <= 1'b0;
            data_sent <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send) begin
                        snap  <= send_data;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    phase <= PH_HDR;
                    cnt   <= 8'd0;
`ifdef DBG_CHECKSUM_EN
                    sum   <= 8'd0;
`endif
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!tx_busy) begin
                        wr_uart <= 1'b1;
                        w_data  <= cur_byte;
                        ack_tmo <= 1'b0;
                        state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // A UART that never raises busy still gets two cycles.
                    if (tx_busy || ack_tmo)
                        state <= S_WAIT_FREE;
                    else
                        ack_tmo <= 1'b1;
                end
                S_WAIT_FREE: begin
                    if (!tx_busy) begin
                        state <= S_ISSUE;
                        case (phase)
                            PH_HDR: phase <= PH_LEN;
                            PH_LEN: begin
                                phase <= PH_DATA;
                                cnt   <= 8'd0;
                            end
                            PH_DATA: begin
                                snap <= snap << 8;
`ifdef DBG_CHECKSUM_EN
                                sum  <= sum + cur_byte;
`endif
                                if (cnt == LAST) begin
`ifdef DBG_CHECKSUM_EN
                                    phase <= PH_CSUM;
`else
                                    state <= S_DONE;
`endif
                                end else begin
                                    cnt <= cnt + 8'd1;
                                end
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_DONE: begin
                    data_sent <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// tb_debug_frame_tx: directed + randomized frames against a queue model.
// Honours DBG_CHECKSUM_EN the same way as the design.
module tb_debug_frame_tx;

    localparam int NB = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            send = 1'b0;
    logic [NB*8-1:0] send_data = '0;
    logic            tx_busy;
    logic            wr_uart;
    logic [7:0]      w_data;
    logic            data_sent;
    logic            busy;
    logic [2:0]      state;

    logic uart_busy = 1'b0;
    logic force_busy = 1'b0;
    logic never_ack = 1'b0;
    int   hold_len = 10;
    int   hold_cnt = 0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int ds_count = 0;
    int wr_viol = 0;
    int first_wr_cyc = -1;
    int send_cyc = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    assign tx_busy = uart_busy | force_busy;

    debug_frame_tx #(
        .DATA_BYTES  (NB),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .send_data (send_data),
        .tx_busy   (tx_busy),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .data_sent (data_sent),
        .busy      (busy),
        .state     (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // UART model and byte capture, on the falling edge.
    always @(negedge clock) begin
        if (data_sent) ds_count++;
        if (wr_uart) begin
            if (tx_busy) wr_viol++;
            if (got.size() == 0) first_wr_cyc = cyc;
            got.push_back(w_data);
        end
        if (uart_busy) begin
            if (hold_cnt <= 1) uart_busy = 1'b0;
            else hold_cnt--;
        end
        if (wr_uart && !never_ack) begin
            uart_busy = 1'b1;
            hold_cnt  = hold_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic void build(input logic [NB*8-1:0] d);
        int s = 0;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NB));
        for (int k = 0; k < NB; k++) begin
            b = 8'(d >> (8 * (NB - 1 - k)));
            exp_q.push_back(b);
            s += int'(b);
        end
`ifdef DBG_CHECKSUM_EN
        exp_q.push_back(8'((256 - (s % 256)) % 256));
`endif
    endfunction

    task automatic start_frame(input logic [NB*8-1:0] d);
        got.delete();
        first_wr_cyc = -1;
        wr_viol = 0;
        build(d);
        send_data = d;
        send = 1'b1;
        send_cyc = cyc;
        step();
        send = 1'b0;
    endtask

    task automatic wait_bytes(input int k, input string tag);
        int n = 0;
        while (got.size() < k && n < 2000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 2000), 1);
    endtask

    task automatic finish_frame(input string tag, input int ds0);
        int n = 0;
        while (ds_count == ds0 && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 3000), 1);
        step();
        check({tag, "_ds"}, 32'(ds_count - ds0), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_viol"}, 32'(wr_viol), 0);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int ds0;
        int relc;
        int nexp;

        step();
        step();
        check("rst_wr", 32'(wr_uart), 0);
        check("rst_wdata", 32'(w_data), 0);
        check("rst_ds", 32'(data_sent), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(state), 0);
        reset = 1'b0;
        step();

        // 1: nominal frame plus minimum send-to-header latency
        hold_len = 10;
        ds0 = ds_count;
        start_frame(32'h11223344);
        check("t1_busy_on", 32'(busy), 1);
        finish_frame("t1", ds0);
        check("t1_latency", 32'(first_wr_cyc), 32'(send_cyc + 3));

        // 2: bus changes after capture
        ds0 = ds_count;
        start_frame(32'h11223344);
        send_data = 32'hFFFFFFFF;
        finish_frame("t2", ds0);

        // 3: UART busy at frame start
        force_busy = 1'b1;
        ds0 = ds_count;
        start_frame(32'hA1B2C3D4);
        repeat (50) step();
        check("t3_nowr", 32'(got.size()), 0);
        check("t3_issue", 32'(state), 2);
        force_busy = 1'b0;
        relc = cyc;
        finish_frame("t3", ds0);
        check("t3_first", 32'(first_wr_cyc), 32'(relc + 1));

        // 4: send pulsed mid-frame is ignored
        ds0 = ds_count;
        start_frame(32'h0BADF00D);
        wait_bytes(3, "t4_wait");
        send = 1'b1;
        step();
        send = 1'b0;
        finish_frame("t4", ds0);
        nexp = exp_q.size();
        repeat (30) step();
        check("t4_nomore", 32'(got.size()), 32'(nexp));
        check("t4_ds_once", 32'(ds_count - ds0), 1);

        // 5: reset mid-frame
        ds0 = ds_count;
        start_frame(32'hCAFEBABE);
        wait_bytes(3, "t5_wait");
        reset = 1'b1;
        step();
        check("t5_wr", 32'(wr_uart), 0);
        check("t5_wdata", 32'(w_data), 0);
        check("t5_ds", 32'(data_sent), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_state", 32'(state), 0);
        reset = 1'b0;
        repeat (15) step();
        check("t5_nods", 32'(ds_count - ds0), 0);
        ds0 = ds_count;
        start_frame(32'h5566EE77);
        finish_frame("t5b", ds0);

        // 6: UART never acknowledges
        never_ack = 1'b1;
        ds0 = ds_count;
        start_frame(32'h11223344);
        finish_frame("t6", ds0);
        never_ack = 1'b0;

        // randomized frames
        for (int r = 0; r < 6; r++) begin
            hold_len = int'($urandom_range(1, 6));
            never_ack = ($urandom_range(0, 3) == 0);
            ds0 = ds_count;
            start_frame($urandom);
            finish_frame($sformatf("rnd%0d", r), ds0);
        end
        never_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
